// File: rtl/vj_ii_pkg.sv
// Shared constants and types for the integral-image front end.
// Frame geometry defaults match the detector's 320x240 grayscale input.
package vj_ii_pkg;

  localparam int IMG_W = 320;
  localparam int IMG_H = 240;
  localparam int PIX_W = 8;
  localparam int II_W  = 32;

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  typedef logic [II_W-1:0]  ii_t;
  typedef logic [PIX_W-1:0] pix_t;

endpackage

// File: rtl/ii_row_buf.sv
// One row of {sum_sq, sum} integral values, read combinationally at the
// current column and overwritten in the same cycle the pixel is accepted.
module ii_row_buf #(
  parameter int DEPTH = vj_ii_pkg::IMG_W,
  parameter int DW    = 2 * vj_ii_pkg::II_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          wr_en,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] rd_data
);
  import vj_ii_pkg::*;

  logic [DW-1:0] mem_q [DEPTH];

  // Read sees the previous row's value; the write lands at the clock edge.
  assign rd_data = mem_q[addr];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/integral_image_gen.sv
// Streaming inclusive integral / squared-integral generator, one pixel per
// cycle in raster order, with a single registered valid/ready output stage.
module integral_image_gen #(
  parameter int IMG_W = vj_ii_pkg::IMG_W,
  parameter int IMG_H = vj_ii_pkg::IMG_H,
  parameter int PIX_W = vj_ii_pkg::PIX_W,
  parameter int II_W  = vj_ii_pkg::II_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic [PIX_W-1:0]         pix_in,
  input  logic                     pix_valid,
  output logic                     pix_ready,
  output logic [II_W-1:0]          ii_out,
  output logic [II_W-1:0]          ii_sq_out,
  output logic [$clog2(IMG_W)-1:0] ii_x,
  output logic [$clog2(IMG_H)-1:0] ii_y,
  output logic                     ii_valid,
  input  logic                     ii_ready,
  output logic                     frame_done
);
  import vj_ii_pkg::*;

  localparam int X_W = $clog2(IMG_W);
  localparam int Y_W = $clog2(IMG_H);
  localparam logic [X_W-1:0] X_LAST = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_H - 1);

  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [II_W-1:0]   row_sum_q, row_sum_d;
  logic [II_W-1:0]   row_sum_sq_q, row_sum_sq_d;
  logic [II_W-1:0]   ii_q, ii_d;
  logic [II_W-1:0]   ii_sq_q, ii_sq_d;
  logic [X_W-1:0]    ii_x_q, ii_x_d;
  logic [Y_W-1:0]    ii_y_q, ii_y_d;
  logic              valid_q, valid_d;
  logic              frame_done_q, frame_done_d;

  logic              accept;
  logic              out_xfer;
  logic [2*PIX_W-1:0] sq;
  logic [II_W-1:0]   rs_new, rss_new;
  logic [II_W-1:0]   above, above_sq;
  logic [II_W-1:0]   sum, sum_sq;
  logic [2*II_W-1:0] rd_data, wr_data;

  assign pix_ready = !valid_q || ii_ready;
  assign accept    = pix_valid && pix_ready && !clear;
  assign out_xfer  = valid_q && ii_ready;

  ii_row_buf #(
    .DEPTH (IMG_W),
    .DW    (2 * II_W),
    .AW    (X_W)
  ) u_row_buf (
    .clock   (clock),
    .wr_en   (accept),
    .addr    (x_q),
    .wr_data (wr_data),
    .rd_data (rd_data)
  );

  // Row 0 never trusts the buffer, so a cleared or fresh frame cannot see stale rows.
  always_comb begin
    sq       = {{PIX_W{1'b0}}, pix_in} * {{PIX_W{1'b0}}, pix_in};
    rs_new   = ((x_q == '0) ? '0 : row_sum_q) + II_W'(pix_in);
    rss_new  = ((x_q == '0) ? '0 : row_sum_sq_q) + II_W'(sq);
    above    = (y_q == '0) ? '0 : rd_data[II_W-1:0];
    above_sq = (y_q == '0) ? '0 : rd_data[2*II_W-1:II_W];
    sum      = rs_new + above;
    sum_sq   = rss_new + above_sq;
    wr_data  = {sum_sq, sum};
  end

  always_comb begin
    x_d          = x_q;
    y_d          = y_q;
    row_sum_d    = row_sum_q;
    row_sum_sq_d = row_sum_sq_q;
    ii_d         = ii_q;
    ii_sq_d      = ii_sq_q;
    ii_x_d       = ii_x_q;
    ii_y_d       = ii_y_q;
    valid_d      = valid_q;
    frame_done_d = 1'b0;

    if (clear) begin
      x_d          = '0;
      y_d          = '0;
      row_sum_d    = '0;
      row_sum_sq_d = '0;
      valid_d      = 1'b0;
    end else begin
      if (out_xfer) begin
        valid_d = 1'b0;
        if (ii_x_q == X_LAST && ii_y_q == Y_LAST) begin
          frame_done_d = 1'b1;
        end
      end
      // A same-cycle accept overrides the drain above, so the stage never bubbles.
      if (accept) begin
        valid_d      = 1'b1;
        ii_d         = sum;
        ii_sq_d      = sum_sq;
        ii_x_d       = x_q;
        ii_y_d       = y_q;
        row_sum_d    = rs_new;
        row_sum_sq_d = rss_new;
        if (x_q == X_LAST) begin
          x_d = '0;
          y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
        end else begin
          x_d = x_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_q          <= '0;
      y_q          <= '0;
      row_sum_q    <= '0;
      row_sum_sq_q <= '0;
      ii_q         <= '0;
      ii_sq_q      <= '0;
      ii_x_q       <= '0;
      ii_y_q       <= '0;
      valid_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      row_sum_q    <= row_sum_d;
      row_sum_sq_q <= row_sum_sq_d;
      ii_q         <= ii_d;
      ii_sq_q      <= ii_sq_d;
      ii_x_q       <= ii_x_d;
      ii_y_q       <= ii_y_d;
      valid_q      <= valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign ii_out     = ii_q;
  assign ii_sq_out  = ii_sq_q;
  assign ii_x       = ii_x_q;
  assign ii_y       = ii_y_q;
  assign ii_valid   = valid_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_integral_image_gen.sv
// Directed bench: a 4x3 instance for the functional/corner cases and a
// 320x240 instance for the full-frame wrap-around values.
module tb_integral_image_gen;

  localparam int SW = 4;
  localparam int SH = 3;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        s_clear, s_valid, s_ready, s_ii_valid, s_ii_ready, s_fd;
  logic [7:0]  s_pix;
  logic [31:0] s_ii, s_sq;
  logic [1:0]  s_x, s_y;

  logic        l_clear, l_valid, l_ready, l_ii_valid, l_ii_ready, l_fd;
  logic [7:0]  l_pix;
  logic [31:0] l_ii, l_sq;
  logic [8:0]  l_x;
  logic [7:0]  l_y;

  integral_image_gen #(.IMG_W(SW), .IMG_H(SH), .PIX_W(8), .II_W(32)) dut_s (
    .clock(clock), .reset(reset), .clear(s_clear), .pix_in(s_pix),
    .pix_valid(s_valid), .pix_ready(s_ready), .ii_out(s_ii), .ii_sq_out(s_sq),
    .ii_x(s_x), .ii_y(s_y), .ii_valid(s_ii_valid), .ii_ready(s_ii_ready),
    .frame_done(s_fd)
  );

  integral_image_gen #(.IMG_W(320), .IMG_H(240), .PIX_W(8), .II_W(32)) dut_l (
    .clock(clock), .reset(reset), .clear(l_clear), .pix_in(l_pix),
    .pix_valid(l_valid), .pix_ready(l_ready), .ii_out(l_ii), .ii_sq_out(l_sq),
    .ii_x(l_x), .ii_y(l_y), .ii_valid(l_ii_valid), .ii_ready(l_ii_ready),
    .frame_done(l_fd)
  );

  typedef struct {
    logic [31:0] ii;
    logic [31:0] sq;
    int          x;
    int          y;
  } exp_t;

  typedef struct {
    logic [7:0]  pix;
    logic [31:0] ii;
    logic [31:0] sq;
  } vec_t;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   fd_count = 0;
  int   l_fd_count = 0;
  int   last_xfer_cyc = -10;
  int   fd0;
  exp_t sb[$];
  exp_t mon_e;
  vec_t ramp[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Scoreboard: every output transfer must match the next expected result in order.
  always @(negedge clock) begin
    if (!reset && s_ii_valid && s_ii_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got ii=%0d at (%0d,%0d), expected no output", s_ii, s_x, s_y);
      end else begin
        mon_e = sb.pop_front();
        chk($sformatf("sb_ii(%0d,%0d)", mon_e.x, mon_e.y), s_ii, mon_e.ii);
        chk($sformatf("sb_sq(%0d,%0d)", mon_e.x, mon_e.y), s_sq, mon_e.sq);
        chk("sb_x", 32'(s_x), mon_e.x);
        chk("sb_y", 32'(s_y), mon_e.y);
        if (mon_e.x == SW - 1 && mon_e.y == SH - 1) last_xfer_cyc = cyc;
      end
    end
    if (s_fd) begin
      fd_count++;
      chk("frame_done_timing", cyc, last_xfer_cyc + 1);
    end
    if (l_fd) l_fd_count++;
  end

  task automatic send(input logic [7:0] p, input logic [31:0] eii, input logic [31:0] esq,
                      input int ex, input int ey);
    int budget = 0;
    s_pix   = p;
    s_valid = 1'b1;
    @(negedge clock);
    while (!s_ready && budget < 50) begin
      budget++;
      @(negedge clock);
    end
    if (!s_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: pix_ready got 0, expected 1 within 50 cycles");
    end else begin
      sb.push_back('{eii, esq, ex, ey});
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ramp[0]  = '{8'd0,  32'd0,  32'd0};
    ramp[1]  = '{8'd1,  32'd1,  32'd1};
    ramp[2]  = '{8'd2,  32'd3,  32'd5};
    ramp[3]  = '{8'd3,  32'd6,  32'd14};
    ramp[4]  = '{8'd4,  32'd4,  32'd16};
    ramp[5]  = '{8'd5,  32'd10, 32'd42};
    ramp[6]  = '{8'd6,  32'd18, 32'd82};
    ramp[7]  = '{8'd7,  32'd28, 32'd140};
    ramp[8]  = '{8'd8,  32'd12, 32'd80};
    ramp[9]  = '{8'd9,  32'd27, 32'd187};
    ramp[10] = '{8'd10, 32'd45, 32'd327};
    ramp[11] = '{8'd11, 32'd66, 32'd506};

    reset = 1'b1;
    s_clear = 1'b0; s_pix = '0; s_valid = 1'b0; s_ii_ready = 1'b1;
    l_clear = 1'b0; l_pix = '0; l_valid = 1'b0; l_ii_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ii_valid", 32'(s_ii_valid), 0);
    chk("rst_ii", s_ii, 0);
    chk("rst_ii_sq", s_sq, 0);
    chk("rst_x", 32'(s_x), 0);
    chk("rst_y", 32'(s_y), 0);
    chk("rst_frame_done", 32'(s_fd), 0);
    chk("rst_pix_ready", 32'(s_ready), 1);
    chk("rst_l_ii_valid", 32'(l_ii_valid), 0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // All-ones frame: ii = sq = (x+1)(y+1)
    fd0 = fd_count;
    for (int y = 0; y < SH; y++)
      for (int x = 0; x < SW; x++)
        send(8'd1, (x + 1) * (y + 1), (x + 1) * (y + 1), x, y);
    idle(3);
    chk("ones_last_ii", s_ii, 12);
    chk("ones_last_sq", s_sq, 12);
    chk("ones_frame_done_count", fd_count - fd0, 1);

    // Ramp frame, table-driven with direct register check after each accept
    fd0 = fd_count;
    for (int i = 0; i < 12; i++) begin
      send(ramp[i].pix, ramp[i].ii, ramp[i].sq, i % SW, i / SW);
      chk($sformatf("ramp_ii[%0d]", i), s_ii, ramp[i].ii);
      chk($sformatf("ramp_sq[%0d]", i), s_sq, ramp[i].sq);
      chk($sformatf("ramp_valid[%0d]", i), 32'(s_ii_valid), 1);
    end
    idle(3);
    chk("ramp_frame_done_count", fd_count - fd0, 1);

    // Backpressure: stall 5 cycles with the 3rd result held and the 4th pixel waiting
    fd0 = fd_count;
    for (int i = 0; i < 3; i++)
      send(ramp[i].pix, ramp[i].ii, ramp[i].sq, i % SW, i / SW);
    s_ii_ready = 1'b0;
    s_pix = ramp[3].pix;
    s_valid = 1'b1;
    repeat (5) begin
      @(negedge clock);
      chk("bp_pix_ready", 32'(s_ready), 0);
      chk("bp_valid_hold", 32'(s_ii_valid), 1);
      chk("bp_ii_hold", s_ii, ramp[2].ii);
      chk("bp_sq_hold", s_sq, ramp[2].sq);
      chk("bp_x_hold", 32'(s_x), 2);
    end
    @(posedge clock);
    #1;
    s_ii_ready = 1'b1;
    for (int i = 3; i < 12; i++)
      send(ramp[i].pix, ramp[i].ii, ramp[i].sq, i % SW, i / SW);
    idle(3);
    chk("bp_last_ii", s_ii, 66);
    chk("bp_last_sq", s_sq, 506);
    chk("bp_frame_done_count", fd_count - fd0, 1);

    // Clear at (2,1) after a partial frame of 9s; the pixel is dropped
    fd0 = fd_count;
    for (int i = 0; i < 6; i++)
      send(8'd9, 9 * (i % SW + 1) * (i / SW + 1), 81 * (i % SW + 1) * (i / SW + 1), i % SW, i / SW);
    s_pix = 8'd1;
    s_valid = 1'b1;
    s_clear = 1'b1;
    @(posedge clock);
    #1;
    s_clear = 1'b0;
    s_valid = 1'b0;
    chk("clr_ii_valid", 32'(s_ii_valid), 0);
    chk("clr_pix_ready", 32'(s_ready), 1);
    for (int y = 0; y < SH; y++)
      for (int x = 0; x < SW; x++)
        send(8'd1, (x + 1) * (y + 1), (x + 1) * (y + 1), x, y);
    idle(3);
    chk("clr_last_ii", s_ii, 12);
    chk("clr_frame_done_count", fd_count - fd0, 1);

    // Back-to-back frames: ramp, then a frame of 200 followed by ones
    fd0 = fd_count;
    for (int i = 0; i < 12; i++)
      send(ramp[i].pix, ramp[i].ii, ramp[i].sq, i % SW, i / SW);
    send(8'd200, 200, 40000, 0, 0);
    chk("b2b_first_ii", s_ii, 200);
    chk("b2b_first_sq", s_sq, 40000);
    for (int i = 1; i < 12; i++)
      send(8'd1, (i % SW + 1) * (i / SW + 1) + 199, (i % SW + 1) * (i / SW + 1) + 39999, i % SW, i / SW);
    idle(3);
    chk("b2b_last_ii", s_ii, 211);
    chk("b2b_frame_done_count", fd_count - fd0, 2);
    chk("sb_drained", sb.size(), 0);

    // Full 320x240 frame of 255s, one pixel per cycle
    l_pix = 8'd255;
    l_valid = 1'b1;
    repeat (76800) @(posedge clock);
    #1;
    l_valid = 1'b0;
    chk("big_ii", l_ii, 32'd19584000);
    chk("big_sq", l_sq, 32'd698952704);
    chk("big_x", 32'(l_x), 319);
    chk("big_y", 32'(l_y), 239);
    chk("big_valid", 32'(l_ii_valid), 1);
    repeat (3) @(posedge clock);
    #1;
    chk("big_frame_done_count", l_fd_count, 1);
    chk("big_drained", 32'(l_ii_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
